// File: rtl/uart_config_rx.sv
// UART 8N1 receiver and command parser driving the global trace enable and
// the configId/configData write bus shared by all building blocks.
module uart_config_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ID_BYTES     = 1,
    parameter int DATA_BYTES   = 1,
    parameter bit TRACE_RESET  = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx,
    output logic                    tracing,
    output logic [8*ID_BYTES-1:0]   configId,
    output logic [8*DATA_BYTES-1:0] configData,
    output logic                    configValid,
    output logic                    frameError
);

    localparam int IW   = 8 * ID_BYTES;
    localparam int DW   = 8 * DATA_BYTES;
    localparam int MAXB = (ID_BYTES > DATA_BYTES) ? ID_BYTES : DATA_BYTES;
    localparam int CW   = $clog2(MAXB) + 1;

    localparam logic [15:0] BIT_RELOAD  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_RELOAD = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] ID_LAST   = CW'(ID_BYTES - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BYTES - 1);

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} r_state_t;
    typedef enum logic [1:0] {P_CMD, P_ID, P_DATA} p_state_t;

    r_state_t      r_state, r_next;
    p_state_t      p_state, p_next;
    logic          rx_meta, rxs;
    logic [15:0]   timer;
    logic [2:0]    bit_cnt;
    logic [7:0]    rx_byte;
    logic          tick, byte_valid, abort;
    logic [CW-1:0] byte_cnt;
    logic [IW-1:0] id_shadow;
    logic [DW-1:0] data_shadow;

    // Synchroniser flops reset to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge value;
            // blocking here would collapse the two synchroniser stages into one.
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= R_IDLE;
        else       r_state <= r_next;
    end

    assign tick = (timer == 16'd0);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one
        // unassigned, which would otherwise infer a latch.
        r_next     = r_state;
        byte_valid = 1'b0;
        abort      = 1'b0;
        unique case (r_state)
            R_IDLE:  if (!rxs) r_next = R_START;
            R_START: if (tick) r_next = rxs ? R_IDLE : R_DATA;
            R_DATA:  if (tick && bit_cnt == 3'd7) r_next = R_STOP;
            R_STOP: begin
                if (tick) begin
                    if (rxs) begin
                        byte_valid = 1'b1;
                        r_next     = R_IDLE;
                    end else begin
                        abort  = 1'b1;
                        r_next = R_BREAK;
                    end
                end
            end
            R_BREAK: if (rxs) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Idle keeps the half-bit delay preloaded; the sampling states reload a full bit on each tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer   <= HALF_RELOAD;
            bit_cnt <= 3'd0;
            rx_byte <= 8'd0;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    timer   <= HALF_RELOAD;
                    bit_cnt <= 3'd0;
                end
                R_START, R_DATA, R_STOP: begin
                    timer <= tick ? BIT_RELOAD : timer - 16'd1;
                    if (r_state == R_DATA && tick) begin
                        rx_byte <= {rxs, rx_byte[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) p_state <= P_CMD;
        else       p_state <= p_next;
    end

    always_comb begin
        p_next = p_state;
        if (abort) begin
            p_next = P_CMD;
        end else if (byte_valid) begin
            unique case (p_state)
                P_CMD:   if (rx_byte == 8'h03) p_next = P_ID;
                P_ID:    if (byte_cnt == ID_LAST) p_next = P_DATA;
                P_DATA:  if (byte_cnt == DATA_LAST) p_next = P_CMD;
                default: p_next = P_CMD;
            endcase
        end
    end

    // Shadows absorb partial packets; the visible bus only changes on the final data byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tracing     <= TRACE_RESET;
            frameError  <= 1'b0;
            configId    <= '0;
            configData  <= '0;
            configValid <= 1'b0;
            byte_cnt    <= '0;
            id_shadow   <= '0;
            data_shadow <= '0;
        end else begin
            configValid <= 1'b0;
            if (abort) begin
                frameError <= 1'b1;
            end else if (byte_valid) begin
                unique case (p_state)
                    P_CMD: begin
                        unique case (rx_byte)
                            8'h01:   tracing    <= 1'b1;
                            8'h02:   tracing    <= 1'b0;
                            8'h03:   byte_cnt   <= '0;
                            8'h04:   frameError <= 1'b0;
                            default: ;
                        endcase
                    end
                    P_ID: begin
                        id_shadow <= (id_shadow << 8) | IW'(rx_byte);
                        byte_cnt  <= (byte_cnt == ID_LAST) ? '0 : byte_cnt + 1'b1;
                    end
                    P_DATA: begin
                        if (byte_cnt == DATA_LAST) begin
                            configId    <= id_shadow;
                            configData  <= (data_shadow << 8) | DW'(rx_byte);
                            configValid <= 1'b1;
                        end else begin
                            data_shadow <= (data_shadow << 8) | DW'(rx_byte);
                            byte_cnt    <= byte_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_config_rx.sv
// Self-checking bench for uart_config_rx: directed packets, random traffic against
// a packet-level model, and a full-rate instance exercised with baud skew.
module tb_uart_config_rx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic        rx2 = 1'b1;
    logic        tracing, tracing2;
    logic [7:0]  cfg_id, cfg_id2;
    logic [15:0] cfg_data, cfg_data2;
    logic        cfg_valid, cfg_valid2;
    logic        frame_err, frame_err2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart_config_rx #(.CLKS_PER_BIT(4), .ID_BYTES(1), .DATA_BYTES(2), .TRACE_RESET(1'b1)) u_dut (
        .clk(clk), .reset(reset), .rx(rx), .tracing(tracing), .configId(cfg_id),
        .configData(cfg_data), .configValid(cfg_valid), .frameError(frame_err));

    uart_config_rx #(.CLKS_PER_BIT(868), .ID_BYTES(1), .DATA_BYTES(2), .TRACE_RESET(1'b1)) u_dut2 (
        .clk(clk), .reset(reset), .rx(rx2), .tracing(tracing2), .configId(cfg_id2),
        .configData(cfg_data2), .configValid(cfg_valid2), .frameError(frame_err2));

    // Strobe monitors: count pulses, record their payload and flag back-to-back strobes.
    int          strobes = 0, consec = 0;
    logic        prev_valid = 1'b0;
    logic [7:0]  s_id;
    logic [15:0] s_data;
    logic [7:0]  s2_id[$];
    logic [15:0] s2_data[$];

    always @(negedge clk) begin
        if (cfg_valid) begin
            strobes++;
            s_id   = cfg_id;
            s_data = cfg_data;
            if (prev_valid) consec++;
        end
        prev_valid = cfg_valid;
        if (cfg_valid2) begin
            s2_id.push_back(cfg_id2);
            s2_data.push_back(cfg_data2);
        end
    end

    // Packet-level reference model.
    logic        m_tracing;
    logic        m_fe;
    logic [7:0]  m_id;
    logic [15:0] m_data;
    int          m_strobes;
    logic [7:0]  pkt[$];

    task automatic model_reset();
        m_tracing = 1'b1;
        m_fe      = 1'b0;
        m_id      = 8'h00;
        m_data    = 16'h0000;
        pkt.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok) begin
            m_fe = 1'b1;
            pkt.delete();
        end else if (pkt.size() == 0) begin
            if (b == 8'h01) m_tracing = 1'b1;
            else if (b == 8'h02) m_tracing = 1'b0;
            else if (b == 8'h03) pkt.push_back(b);
            else if (b == 8'h04) m_fe = 1'b0;
        end else begin
            pkt.push_back(b);
            if (pkt.size() == 4) begin
                m_id   = pkt[1];
                m_data = {pkt[2], pkt[3]};
                m_strobes++;
                pkt.delete();
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit which, input logic v, input int n);
        if (which) rx2 = v;
        else       rx  = v;
        repeat (n) @(posedge clk);
    endtask

    // Start bit, 8 data bits LSB first, stop bit; the line is left idle-high afterwards.
    task automatic send_raw(input bit which, input logic [7:0] b, input bit stop_ok, input int bc);
        drive(which, 1'b0, bc);
        for (int i = 0; i < 8; i++) drive(which, b[i], bc);
        drive(which, stop_ok, bc);
        if (which) rx2 = 1'b1;
        else       rx  = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input bit stop_ok = 1'b1);
        send_raw(1'b0, b, stop_ok, 4);
        model_byte(b, stop_ok);
        repeat (8) @(posedge clk);
    endtask

    task automatic check_all(input string tag);
        @(negedge clk);
        check({tag, ".tracing"}, 32'(tracing), 32'(m_tracing));
        check({tag, ".frameError"}, 32'(frame_err), 32'(m_fe));
        check({tag, ".configId"}, 32'(cfg_id), 32'(m_id));
        check({tag, ".configData"}, 32'(cfg_data), 32'(m_data));
        check({tag, ".strobes"}, 32'(strobes), 32'(m_strobes));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [7:0] b;
        bit         ok;
        int         bc;

        m_strobes = 0;
        do_reset();
        repeat (10) @(posedge clk);
        check_all("reset");
        check("reset.configValid", 32'(cfg_valid), 32'd0);

        send(8'h02);  check_all("trace_off");
        send(8'h01);  check_all("trace_on");

        send(8'h03);  check_all("wr1.cmd");
        send(8'h05);  check_all("wr1.id");
        send(8'hAB);  check_all("wr1.d0");
        send(8'hCD);  check_all("wr1.d1");
        check("wr1.strobe_id", 32'(s_id), 32'h05);
        check("wr1.strobe_data", 32'(s_data), 32'hABCD);
        repeat (20) @(posedge clk);
        check_all("wr1.hold");

        send(8'h03); send(8'h07); send(8'h11);
        send(8'h22, 1'b0);  check_all("ferr.bad_stop");
        send(8'h03); send(8'h07); send(8'h11); send(8'h22);
        check_all("wr2");
        check("wr2.strobe_data", 32'(s_data), 32'h1122);
        send(8'h04);  check_all("ferr.clear");

        // One-cycle low glitch on an idle line must not decode a byte.
        @(posedge clk); rx = 1'b0;
        @(posedge clk); rx = 1'b1;
        repeat (20) @(posedge clk);
        check_all("glitch");
        send(8'h7F);  check_all("unknown_cmd");
        send(8'h03); send(8'h0E); send(8'h5A); send(8'hA5);
        check_all("after_unknown");

        send(8'h02);
        send(8'h03); send(8'h09);
        do_reset();
        check_all("mid_pkt_reset");
        check("mid_pkt_reset.configValid", 32'(cfg_valid), 32'd0);
        send(8'h03); send(8'h09); send(8'h00); send(8'h01);
        check_all("wr_after_reset");

        // Random traffic biased towards commands so packets actually complete.
        for (int n = 0; n < 60; n++) begin
            b  = ($urandom_range(0, 9) < 5) ? 8'($urandom_range(1, 4)) : 8'($urandom);
            ok = ($urandom_range(0, 9) != 0);
            send(b, ok);
            check_all($sformatf("rand%0d", n));
        end
        check("no_consecutive_strobes", 32'(consec), 32'd0);

        // Full-rate instance: two packets back to back at +2% and -2% bit time.
        for (int k = 0; k < 8; k++) begin
            bc = (k < 4) ? 885 : 851;
            case (k)
                0, 4:    b = 8'h03;
                1:       b = 8'h12;
                2:       b = 8'h34;
                3:       b = 8'h56;
                5:       b = 8'h9A;
                6:       b = 8'hBC;
                default: b = 8'hDE;
            endcase
            send_raw(1'b1, b, 1'b1, bc);
        end
        repeat (1000) @(posedge clk);
        @(negedge clk);
        check("skew.strobe_count", 32'(s2_id.size()), 32'd2);
        if (s2_id.size() == 2) begin
            check("skew.id0", 32'(s2_id[0]), 32'h12);
            check("skew.data0", 32'(s2_data[0]), 32'h3456);
            check("skew.id1", 32'(s2_id[1]), 32'h9A);
            check("skew.data1", 32'(s2_data[1]), 32'hBCDE);
        end
        check("skew.configId", 32'(cfg_id2), 32'h9A);
        check("skew.configData", 32'(cfg_data2), 32'hBCDE);
        check("skew.frameError", 32'(frame_err2), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_config_rx.md
Name: uart_config_rx

Overview:
- Parametrised UART receiver and command parser.
- Receives 8N1 serial bytes from the host PC, decodes trace-control and configuration-write packets, and drives the global tracing enable and the configId/configData bus to all building blocks.
- configValid is a one-cycle write strobe for that bus; blocks latch configData when it is high and configId matches.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200). Legal range is 4 or more.
- ID_BYTES, 1, bytes in configId. configId width = 8*ID_BYTES.
- DATA_BYTES, 1, bytes in configData. configData width = 8*DATA_BYTES.
- TRACE_RESET, 1, value of tracing after reset.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- rx  input  1  UART serial line; asynchronous; idles high
- tracing  output  1  global trace enable
- configId  output  8*ID_BYTES  target block identifier
- configData  output  8*DATA_BYTES  configuration payload
- configValid  output  1  one-cycle strobe; configId/configData are valid while high
- frameError  output  1  sticky; set on a bad stop bit

Behaviour:
Reset:
- Applies at any time, including mid-byte or mid-packet.
- Clears all state: tracing=TRACE_RESET, configId=0, configData=0, configValid=0, frameError=0. Both FSMs go to idle.

Input synchroniser:
- rx passes through a 2-flop synchroniser. rxs denotes the synchronised signal.
- Synchroniser flops reset to 1.

Byte receiver FSM (R_IDLE, R_START, R_DATA, R_STOP, R_BREAK), 16-bit bit-timer:
- R_IDLE: when rxs=0, load the timer and go to R_START.
- R_START: wait CLKS_PER_BIT/2 cycles (integer divide), then re-sample.
  - rxs=0: go to R_DATA.
  - rxs=1: glitch; return to R_IDLE.
- R_DATA: sample 8 bits, each CLKS_PER_BIT cycles after the previous sample. Bits arrive LSB first, shift right.
- R_STOP: sample CLKS_PER_BIT cycles after bit 7.
  - rxs=1: assert internal byteValid for one cycle and go to R_IDLE.
  - rxs=0: set frameError, discard the byte, pulse internal abort, go to R_BREAK.
- R_BREAK: wait for rxs=1, then go to R_IDLE.

Packet parser FSM (P_CMD, P_ID, P_DATA), advances only on byteValid:
- P_CMD:
  - 0x01: tracing<=1.
  - 0x02: tracing<=0.
  - 0x03: clear the byte counter and go to P_ID.
  - 0x04: clear frameError.
  - Any other value: ignored.
  - tracing and frameError change in the cycle after the byteValid cycle.
- P_ID: collect ID_BYTES bytes into a shadow register, MSB byte first, then go to P_DATA.
- P_DATA: collect DATA_BYTES bytes, MSB byte first.
  - On the last byte, copy the shadows to configId/configData and assert configValid for exactly one cycle. These are registered: same cycle as the tracing update timing.
  - Then return to P_CMD.
- configId/configData hold their value until the next complete write. Partial packets never alter the outputs.
- abort in any state returns the parser to P_CMD and drops the partial packet. The abort does not change tracing, configId or configData.
- byteValid and abort are mutually exclusive by construction.

Latency:
- The rx stop-bit midpoint to byteValid is 2 synchroniser cycles plus the sample cycle.
- Outputs update 1 cycle after byteValid.
- configValid is never asserted two cycles in a row.

Width rules:
- Timer is 16 bits; CLKS_PER_BIT must be less than 65536.
- Byte counter width is clog2(max(ID_BYTES,DATA_BYTES))+1.

Test Plan:
Settings for all scenarios unless stated: CLKS_PER_BIT=4, ID_BYTES=1, DATA_BYTES=2, TRACE_RESET=1.
- Reset, then idle -> tracing=1, configId=0, configData=0, configValid=0, frameError=0. Send 0x02 -> tracing=0 after the stop bit. Send 0x01 -> tracing=1.
- Send 0x03,0x05,0xAB,0xCD -> configValid high exactly 1 cycle with configId=0x05, configData=0xABCD. Outputs hold afterwards. No strobe occurs after the 0x03 or 0x05 bytes.
- Send 0x03,0x07,0x11, then a byte with stop bit=0 -> frameError=1, no configValid, configId stays 0x05. Send 0x03,0x07,0x11,0x22 -> strobe with 0x07/0x1122. Send 0x04 -> frameError=0.
- 1-cycle low glitch on rx while idle -> no byte is decoded and no state change. Unknown command 0x7F -> ignored, parser stays in P_CMD.
- Assert reset while mid-packet (after 0x03,0x09) -> outputs return to reset values. Then send a full 0x03,0x09,0x00,0x01 -> single strobe with 0x09/0x0001.
- CLKS_PER_BIT=868 with back-to-back bytes (no idle bit between stop and next start) and ±2% baud skew -> all bytes decoded correctly.
